store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the execute stage and the 64-word data memory. It accepts stores from the CPU without stalling and retires them to memory on cycles when the load path does not need the single memory port. It also resolves load-after-store hazards against pending entries and supports a software-visible flush.

## Interface
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- MEM_AW, 6, number of low address bits used for hazard compare (64-word memory).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- st_valid  in  1  store request.
- st_addr  in  32  store word address.
- st_data  in  32  store data.
- st_ready  out  1  buffer can accept a store; equals count<DEPTH and state==RUN.
- ld_valid  in  1  load request.
- ld_addr  in  32  load word address.
- ld_data  out  32  load result; 0 when ld_valid=0 or cpu_stall=1.
- cpu_stall  out  1  load cannot complete this cycle.
- flush_req  in  1  one-cycle request to drain all entries.
- flush_done  out  1  one-cycle pulse when a flush completes.
- mem_read  out  1  data memory read enable.
- mem_write  out  1  data memory write enable; memory writes at the negedge.
- mem_address  out  32  data memory address.
- mem_writedata  out  32  data memory write data.
- mem_readdata  in  32  data memory read data, combinational.
- count  out  clog2(DEPTH+1)  occupied entries.
- empty  out  1  count==0.

## Operation
- Storage is a circular FIFO of {addr, data}, with head/tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH.
- **Enqueue:** st_valid & st_ready at posedge writes the entry at the tail. A full buffer rejects the store even if a pop occurs in the same cycle.
- **Hit:** a load hits when ld_addr[MEM_AW-1:0] matches the address of any entry currently held. A store entering in the same cycle is not compared.
- **Port arbitration, highest priority first:**
  1. Load with no hit: mem_read=1, mem_address=ld_addr, ld_data=mem_readdata. No drain this cycle.
  2. Otherwise, if the buffer is non-empty: mem_write=1, mem_address=head addr, mem_writedata=head data. The head is popped at the next posedge.
  3. Otherwise the port is idle: all mem_* outputs are 0.
- Simultaneous push and pop leaves count unchanged.
- **FSM:**
  - RUN: flush_req goes to FLUSHING.
  - FLUSHING: st_ready=0 and draining continues. When count reaches 0, flush_done pulses and the state returns to RUN. A flush_req while empty takes one cycle: RUN→FLUSHING→RUN, with flush_done in the second cycle.
  - flush_req while already in FLUSHING is ignored.
- **Reset (including mid-drain or mid-flush):**
  - Pointers and count go to 0 and the state goes to RUN.
  - All pending stores are discarded; the memory clears on the same rst.
  - Outputs under reset: st_ready=1, cpu_stall=0, flush_done=0, mem_*=0, count=0, empty=1, ld_data=0.

## Timing
- Store accepted at edge N: mem_write asserts in cycle N→N+1 (when the port is free), memory updates at that cycle's negedge, and the entry pops at edge N+1.
- A load with no hit completes in the same cycle (zero latency).
- Hit behaviour depends on Configuration. A stalled load sees no progress on the load port. The drain continues, so a stall clears after at most DEPTH cycles.

## Configuration
- `STORE_BUFFER_FWD_EN`:
  - **Defined:** a hit returns the data of the youngest matching entry, with cpu_stall=0. The memory port is free for the drain that cycle.
  - **Undefined:** a hit forces cpu_stall=1 until no matching entry remains, then the load reads memory. No compare-priority logic is built beyond the hit detection.

## Structure
- Package store_buffer_pkg holds:
  - the state typedef {RUN, FLUSHING};
  - the default DEPTH and MEM_AW constants;
  - the entry struct {addr, data}.
- Sub-module sb_match: DEPTH-way address comparator with valid masking relative to head/tail. It outputs a hit flag and, under the macro, the youngest-match index.

## Test plan
- **Basic drain:** store addr 5 data 0xDEADBEEF with no loads → mem_write=1, address 5 in the next cycle; count returns 0; a load of 5 two cycles later returns 0xDEADBEEF.
- **Full:** 4 stores in consecutive cycles while a non-hitting load holds the port → st_ready=0 with count=4. Release the load → 4 drains occur in FIFO order.
- **Hit, two cases** (stores to addr 3: 0x11 then 0x22, then a load of 3 while both are still buffered):
  - With `STORE_BUFFER_FWD_EN` → ld_data=0x22 and cpu_stall=0.
  - Without it → cpu_stall held until both entries drain, then ld_data=0x22.
- **Flush with 3 entries:** flush_req → st_ready=0; flush_done pulses exactly once, on the cycle count reaches 0. Flush on an empty buffer → flush_done one cycle later.
- **Wrap-around:** 10 store/drain pairs → pointers wrap and memory contents match all 10 writes.
- **Reset mid-drain:** assert rst with count=3 → count=0, empty=1, mem_write=0 immediately, and no further writes occur.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the store buffer.
// STORE_BUFFER_FWD_EN (optional) enables store-to-load forwarding in the users of this package.
package store_buffer_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_MEM_AW = 6;

  typedef logic [0:0] sb_state_t;
  localparam sb_state_t RUN      = 1'b0;
  localparam sb_state_t FLUSHING = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// DEPTH-way load address comparator over the live window [head, head+count).
// With STORE_BUFFER_FWD_EN defined it also reports the youngest matching slot.
module sb_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int MEM_AW = SB_MEM_AW,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0][MEM_AW-1:0] addrs_i,
  input  logic [PW-1:0]                head_i,
  input  logic [CW-1:0]                count_i,
  input  logic [MEM_AW-1:0]            ld_addr_i,
`ifdef STORE_BUFFER_FWD_EN
  output logic [PW-1:0]                match_idx_o,
`endif
  output logic                         hit_o
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit_o = 1'b0;
    idx   = '0;
`ifdef STORE_BUFFER_FWD_EN
    match_idx_o = head_i;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if ((CW'(k) < count_i) && (addrs_i[idx] == ld_addr_i)) begin
        hit_o = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        match_idx_o = idx;
`endif
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of the single-port data memory, with hazard detection and flush.
// Define STORE_BUFFER_FWD_EN to forward hit data instead of stalling the load.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int MEM_AW = SB_MEM_AW,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  output logic [31:0]   ld_data,
  output logic          cpu_stall,
  input  logic          flush_req,
  output logic          flush_done,
  output logic          mem_read,
  output logic          mem_write,
  output logic [31:0]   mem_address,
  output logic [31:0]   mem_writedata,
  input  logic [31:0]   mem_readdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output sb_state_t     dbg_state
);

  // A store transfers when st_valid && st_ready at posedge; st_ready never
  // depends on st_valid, and a full buffer refuses even if it pops that cycle.

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  sb_entry_t     entries_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  sb_state_t     state_q, state_d;

  logic [DEPTH-1:0][MEM_AW-1:0] match_addrs;
  logic hit;
  logic push, pop, load_port;
`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] match_idx;
`endif

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      match_addrs[k] = entries_q[k].addr[MEM_AW-1:0];
    end
  end

  sb_match #(.DEPTH(DEPTH), .MEM_AW(MEM_AW)) u_match (
    .addrs_i     (match_addrs),
    .head_i      (head_q),
    .count_i     (count_q),
    .ld_addr_i   (ld_addr[MEM_AW-1:0]),
`ifdef STORE_BUFFER_FWD_EN
    .match_idx_o (match_idx),
`endif
    .hit_o       (hit)
  );

  assign st_ready   = (count_q != FULL_CNT) && (state_q == RUN);
  assign push       = st_valid && st_ready;
  // A missing load owns the port; otherwise the head drains.
  assign load_port  = ld_valid && !hit && !rst;
  assign pop        = !load_port && (count_q != '0);
  assign flush_done = (state_q == FLUSHING) && (count_q == '0);
  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign dbg_state  = state_q;

  always_comb begin
    mem_read      = load_port;
    mem_write     = pop;
    mem_address   = 32'd0;
    mem_writedata = 32'd0;
    if (load_port) begin
      mem_address = ld_addr;
    end else if (pop) begin
      mem_address   = entries_q[head_q].addr;
      mem_writedata = entries_q[head_q].data;
    end
  end

  always_comb begin
    ld_data   = 32'd0;
    cpu_stall = 1'b0;
    if (ld_valid && !rst) begin
      if (!hit) begin
        ld_data = mem_readdata;
      end else begin
`ifdef STORE_BUFFER_FWD_EN
        ld_data = entries_q[match_idx].data;
`else
        cpu_stall = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    state_d = state_q;
    case (state_q)
      RUN:      if (flush_req) state_d = FLUSHING;
      FLUSHING: if (count_q == '0) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= RUN;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Payload needs no reset: slots outside the live window are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[tail_q] <= '{addr: st_addr, data: st_data};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic against a queue model.
// Expectations follow STORE_BUFFER_FWD_EN the same way the DUT build does.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid;
  logic [31:0]   st_addr, st_data;
  logic          st_ready;
  logic          ld_valid;
  logic [31:0]   ld_addr, ld_data;
  logic          cpu_stall;
  logic          flush_req, flush_done;
  logic          mem_read, mem_write;
  logic [31:0]   mem_address, mem_writedata, mem_readdata;
  logic [CW-1:0] count;
  logic          empty;
  logic [0:0]    dbg_state;

  logic [31:0] mem_tb [64];
  assign mem_readdata = mem_tb[mem_address[5:0]];

  store_buffer #(.DEPTH(DEPTH), .MEM_AW(6)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .cpu_stall(cpu_stall),
    .flush_req(flush_req), .flush_done(flush_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .count(count), .empty(empty), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem_tb[i] <= 32'd0;
    end else if (mem_write) begin
      mem_tb[mem_address[5:0]] <= mem_writedata;
    end
  end

  // ---------------- reference model ----------------
  logic [63:0] exp_q[$];          // pending stores {addr, data}, oldest first
  logic [31:0] ref_mem [64];
  bit          flushing;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    flushing = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
  endtask

  task automatic check_reset_outputs();
    check("rst_st_ready",  32'(st_ready),   32'd1);
    check("rst_cpu_stall", 32'(cpu_stall),  32'd0);
    check("rst_flush_done",32'(flush_done), 32'd0);
    check("rst_mem_read",  32'(mem_read),   32'd0);
    check("rst_mem_write", 32'(mem_write),  32'd0);
    check("rst_mem_addr",  mem_address,     32'd0);
    check("rst_mem_wdata", mem_writedata,   32'd0);
    check("rst_count",     32'(count),      32'd0);
    check("rst_empty",     32'(empty),      32'd1);
    check("rst_ld_data",   ld_data,         32'd0);
  endtask

  // ---------------- driver: one cycle, entered and left at posedge+1 ----------------
  task automatic step(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                      input bit lv, input logic [31:0] la, input bit fr);
    bit hit, ldp, wr, rdy, fdone;
    logic [31:0] young, e_addr, e_wdata, e_ld;
    bit e_stall;
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la; flush_req = fr;
    #2;
    hit = 1'b0; young = 32'd0;
    foreach (exp_q[i]) begin
      if (exp_q[i][37:32] == la[5:0]) begin
        hit = 1'b1;
        young = exp_q[i][31:0];
      end
    end
    ldp   = lv && !hit;
    wr    = !ldp && (exp_q.size() > 0);
    rdy   = (exp_q.size() < DEPTH) && !flushing;
    fdone = flushing && (exp_q.size() == 0);
    e_addr = 32'd0; e_wdata = 32'd0;
    if (ldp) e_addr = la;
    else if (wr) begin
      e_addr  = exp_q[0][63:32];
      e_wdata = exp_q[0][31:0];
    end
`ifdef STORE_BUFFER_FWD_EN
    e_stall = 1'b0;
    e_ld    = !lv ? 32'd0 : (hit ? young : ref_mem[la[5:0]]);
`else
    e_stall = lv && hit;
    e_ld    = ldp ? ref_mem[la[5:0]] : 32'd0;
`endif
    check("st_ready",      32'(st_ready),   32'(rdy));
    check("count",         32'(count),      32'(exp_q.size()));
    check("empty",         32'(empty),      32'(exp_q.size() == 0));
    check("mem_read",      32'(mem_read),   32'(ldp));
    check("mem_write",     32'(mem_write),  32'(wr));
    check("mem_address",   mem_address,     e_addr);
    check("mem_writedata", mem_writedata,   e_wdata);
    check("flush_done",    32'(flush_done), 32'(fdone));
    check("state",         32'(dbg_state),  32'(flushing));
    check("cpu_stall",     32'(cpu_stall),  32'(e_stall));
    check("ld_data",       ld_data,         e_ld);
    // advance the model across the coming edge
    if (wr) begin
      ref_mem[exp_q[0][37:32]] = exp_q[0][31:0];
      void'(exp_q.pop_front());
    end
    if (sv && rdy) exp_q.push_back({sa, sd});
    if (fdone) flushing = 1'b0;
    else if (!flushing && fr) flushing = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic load(input logic [31:0] a);
    step(1'b0, 32'd0, 32'd0, 1'b1, a, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    st_valid = 1'b1; st_addr = 32'd7; st_data = 32'h55; flush_req = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'd5;
    model_reset();
    @(posedge clk); #1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // basic drain
    step(1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0);
    idle(2);
    load(32'd5);

    // full: a missing load holds the port while four stores fill the buffer
    for (int i = 0; i < 5; i++) step(1'b1, 32'd20 + 32'(i), 32'hA000 + 32'(i), 1'b1, 32'd40, 1'b0);
    idle(5);
    for (int i = 0; i < 5; i++) load(32'd20 + 32'(i));

    // hit: two stores to address 3, then a held load of 3
    step(1'b1, 32'd3, 32'h11, 1'b1, 32'd40, 1'b0);
    step(1'b1, 32'd3, 32'h22, 1'b1, 32'd40, 1'b0);
    for (int i = 0; i < 5; i++) load(32'h0000_0103);

    // flush with three entries, a repeated flush_req and a refused store while flushing
    for (int i = 0; i < 3; i++) step(1'b1, 32'd30 + 32'(i), 32'hF0 + 32'(i), 1'b1, 32'd41, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 32'd33, 32'hF3, 1'b0, 32'd0, 1'b1);
    idle(4);
    // flush on an empty buffer
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    idle(2);

    // wrap-around: ten store/drain pairs
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'd10 + 32'(i), $urandom(), 1'b0, 32'd0, 1'b0);
      idle(1);
    end
    for (int i = 0; i < 10; i++) load(32'd10 + 32'(i));

    // reset mid-drain with three entries
    for (int i = 0; i < 3; i++) step(1'b1, 32'd50 + 32'(i), 32'hBB00 + 32'(i), 1'b1, 32'd42, 1'b0);
    st_valid = 1'b0; ld_valid = 1'b0;
    #1;
    check("pre_rst_mem_write", 32'(mem_write), 32'd1);
    check("pre_rst_count",     32'(count),     32'd3);
    #1;
    rst = 1'b1; ld_valid = 1'b1; ld_addr = 32'd50;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0; ld_valid = 1'b0;
    idle(3);
    for (int i = 0; i < 3; i++) load(32'd50 + 32'(i));

    // random traffic with frequent address collisions
    for (int n = 0; n < 500; n++) begin
      logic [31:0] sa, la;
      sa = ($urandom() & 32'hFFFF_FFC0) | 32'($urandom_range(0, 7));
      la = ($urandom() & 32'hFFFF_FFC0) | 32'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), sa, $urandom(), $urandom_range(0, 2) == 0, la,
           $urandom_range(0, 31) == 0);
    end
    idle(8);
    for (int i = 0; i < 8; i++) load(32'(i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
